fp_op_sequencer: RTL and testbench

FP_OP_SEQUENCER -- requirements
Module: fp_op_sequencer

---
 rtl/fp_op_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_fp_op_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_op_sequencer.sv
// Sequences buffered IEEE-754 operand pairs through an external multi-cycle adder:
// FIFO in, issue/wait/capture/release handshake with the adder, one result register out.
module fp_op_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        add_start,
  output logic        add_reset,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic        add_valid,
  input  logic [31:0] add_sum,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_sum,
  output logic        out_timeout,
  output logic        busy,
  output logic [4:0]  level
);

  localparam int              AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              CW        = $clog2(TIMEOUT + 1);
  localparam logic [4:0]      DEPTH_L   = 5'(FIFO_DEPTH);
  localparam logic [CW-1:0]   WAIT_LAST = CW'(TIMEOUT - 1);
  localparam logic [31:0]     QNAN      = 32'h7FC00000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_RELEASE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [31:0]     r_mem_a [FIFO_DEPTH];
  logic [31:0]     r_mem_b [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [4:0]      r_count;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;

  logic            r_start_cnt;
  logic [CW-1:0]   r_wait_cnt;
  logic            r_to_flag;
  logic            r_rst_hold;

  logic [31:0]     r_add_a;
  logic [31:0]     r_add_b;
  logic            r_out_valid;
  logic [31:0]     r_out_sum;
  logic            r_out_timeout;

  assign w_full   = (r_count == DEPTH_L);
  assign w_empty  = (r_count == 5'd0);
  assign w_push   = in_valid && !w_full;
  assign w_pop    = (r_state == S_IDLE) && !w_empty && !r_out_valid;

  assign in_ready = !w_full;
  assign level    = r_count;
  assign busy     = !w_empty || (r_state != S_IDLE);

  // add_start is masked during reset so it can never overlap the forced add_reset.
  assign add_start = (r_state == S_ISSUE) && !reset;
  assign add_reset = reset || r_rst_hold || (r_state == S_RELEASE);

  assign add_a       = r_add_a;
  assign add_b       = r_add_b;
  assign out_valid   = r_out_valid;
  assign out_sum     = r_out_sum;
  assign out_timeout = r_out_timeout;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr] <= in_a;
      r_mem_b[r_wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 5'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Holds add_reset for one extra cycle after reset is released.
  always_ff @(posedge clk) begin
    r_rst_hold <= reset;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_pop) w_state_nxt = S_ISSUE;
      S_ISSUE:   if (r_start_cnt) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (add_valid)                     w_state_nxt = S_CAPTURE;
        else if (r_wait_cnt == WAIT_LAST)  w_state_nxt = S_RELEASE;
      end
      S_CAPTURE: w_state_nxt = S_RELEASE;
      S_RELEASE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_start_cnt <= 1'b0;
      r_wait_cnt  <= '0;
      r_to_flag   <= 1'b0;
    end else begin
      case (r_state)
        S_ISSUE: r_start_cnt <= !r_start_cnt;
        S_WAIT: begin
          if (add_valid) begin
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_wait_cnt <= '0;
            r_to_flag  <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
          end
        end
        S_RELEASE: r_to_flag <= 1'b0;
        default: ;
      endcase
    end
  end

  // Result loads only happen while out_valid is low, since issue waits for an empty output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_add_a       <= 32'd0;
      r_add_b       <= 32'd0;
      r_out_valid   <= 1'b0;
      r_out_sum     <= 32'd0;
      r_out_timeout <= 1'b0;
    end else begin
      if (w_pop) begin
        r_add_a <= r_mem_a[r_rd_ptr];
        r_add_b <= r_mem_b[r_rd_ptr];
      end
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      if (r_state == S_CAPTURE) begin
        r_out_sum     <= add_sum;
        r_out_timeout <= 1'b0;
        r_out_valid   <= 1'b1;
      end else if ((r_state == S_RELEASE) && r_to_flag) begin
        r_out_sum     <= QNAN;
        r_out_timeout <= 1'b1;
        r_out_valid   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fp_op_sequencer.sv
// Directed bench for fp_op_sequencer with a behavioural adder that answers from a
// hand-computed single-precision sum table.
module tb_fp_op_sequencer;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        add_start;
  logic        add_reset;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_valid;
  logic [31:0] add_sum;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_timeout;
  logic        busy;
  logic [4:0]  level;

  int n_total = 0;
  int n_pass  = 0;

  int model_lat   = 6;
  bit model_never = 1'b0;
  bit m_armed = 1'b0;
  int m_cnt   = 0;
  bit m_valid = 1'b0;

  int n_rst_pulses = 0;
  int n_issue      = 0;
  int n_collide    = 0;
  int gap          = 0;
  int last_gap     = 0;
  bit prev_rst     = 1'b0;
  bit prev_start   = 1'b0;

  logic [32:0] res_q[$];

  always #5 clk = ~clk;

  fp_op_sequencer #(.FIFO_DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .add_start(add_start), .add_reset(add_reset), .add_a(add_a), .add_b(add_b),
    .add_valid(add_valid), .add_sum(add_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_timeout(out_timeout), .busy(busy), .level(level)
  );

  function automatic logic [31:0] fp_lut(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h3F800000_40000000: fp_lut = 32'h40400000;  // 1 + 2 = 3
      64'h40000000_40000000: fp_lut = 32'h40800000;  // 2 + 2 = 4
      64'h3F800000_3F800000: fp_lut = 32'h40000000;  // 1 + 1 = 2
      64'h40400000_3F800000: fp_lut = 32'h40800000;  // 3 + 1 = 4
      64'h40A00000_40000000: fp_lut = 32'h40E00000;  // 5 + 2 = 7
      64'h41000000_3F800000: fp_lut = 32'h41100000;  // 8 + 1 = 9
      64'h3F000000_3F000000: fp_lut = 32'h3F800000;  // 0.5 + 0.5 = 1
      default:               fp_lut = 32'hDEADBEEF;
    endcase
  endfunction

  assign add_valid = m_valid;
  assign add_sum   = fp_lut(add_a, add_b);

  always @(posedge clk) begin
    if (add_reset) begin
      m_armed <= 1'b0;
      m_cnt   <= 0;
      m_valid <= 1'b0;
    end else if (add_start) begin
      m_armed <= 1'b1;
      m_cnt   <= 0;
      m_valid <= 1'b0;
    end else if (m_armed) begin
      m_cnt <= m_cnt + 1;
      if (!model_never && (m_cnt + 1 >= model_lat)) m_valid <= 1'b1;
    end
  end

  always @(posedge clk) begin
    prev_rst   <= add_reset;
    prev_start <= add_start;
    if (add_reset && !prev_rst) begin
      n_rst_pulses <= n_rst_pulses + 1;
      last_gap     <= gap;
    end
    if (add_start && !prev_start) n_issue <= n_issue + 1;
    if (add_start && add_reset)   n_collide <= n_collide + 1;
    if (add_start)                gap <= 0;
    else if (!add_reset)          gap <= gap + 1;
    if (out_valid && out_ready)   res_q.push_back({out_timeout, out_sum});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    int t = 0;
    while (!in_ready && t < 300) begin @(negedge clk); t++; end
    if (!in_ready) chk("push_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_a = a; in_b = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_ov(input string tag);
    int t = 0;
    while (!out_valid && t < 300) begin @(negedge clk); t++; end
    if (!out_valid) chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic check_q(input string tag, input logic [31:0] exp_sum, input logic exp_to);
    int t = 0;
    logic [32:0] r;
    while (res_q.size() == 0 && t < 300) begin @(negedge clk); t++; end
    if (res_q.size() == 0) begin
      chk({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      r = res_q.pop_front();
      chk({tag, "_sum"}, r[31:0], exp_sum);
      chk({tag, "_to"}, {31'd0, r[32]}, {31'd0, exp_to});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int snap;
    int t;
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("rst_add_reset_during", {31'd0, add_reset}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_add_reset_after", {31'd0, add_reset}, 32'd1);
    chk("rst_level",     {27'd0, level},       32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},    32'd1);
    chk("rst_out_valid", {31'd0, out_valid},   32'd0);
    chk("rst_out_sum",   out_sum,              32'd0);
    chk("rst_out_to",    {31'd0, out_timeout}, 32'd0);
    chk("rst_add_start", {31'd0, add_start},   32'd0);
    chk("rst_add_a",     add_a,                32'd0);
    chk("rst_add_b",     add_b,                32'd0);
    chk("rst_busy",      {31'd0, busy},        32'd0);
    @(negedge clk);
    chk("rst_add_reset_released", {31'd0, add_reset}, 32'd0);

    // Single operation
    out_ready = 1'b1; model_lat = 6;
    snap = n_rst_pulses;
    push(32'h3F800000, 32'h40000000);
    check_q("single", 32'h40400000, 1'b0);
    idle(3);
    chk("single_rst_pulses", 32'(n_rst_pulses - snap), 32'd1);

    // Fill: first pair issues and parks its result, the next four fill the FIFO
    out_ready = 1'b0;
    push(32'h3F800000, 32'h40000000);
    push(32'h40000000, 32'h40000000);
    push(32'h3F800000, 32'h3F800000);
    push(32'h40400000, 32'h3F800000);
    push(32'h40A00000, 32'h40000000);
    wait_ov("fill");
    chk("fill_level",    {27'd0, level},    32'd4);
    chk("fill_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1; in_a = 32'h41000000; in_b = 32'h3F800000;
    idle(5);
    chk("fill_hold_level", {27'd0, level}, 32'd4);
    out_ready = 1'b1;
    t = 0;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    chk("fill_sixth_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check_q("fill1", 32'h40400000, 1'b0);
    check_q("fill2", 32'h40800000, 1'b0);
    check_q("fill3", 32'h40000000, 1'b0);
    check_q("fill4", 32'h40800000, 1'b0);
    check_q("fill5", 32'h40E00000, 1'b0);
    check_q("fill6", 32'h41100000, 1'b0);

    // Timeout, then the queued pair proceeds normally
    idle(3);
    model_never = 1'b1;
    snap = n_rst_pulses;
    push(32'h3F800000, 32'h40000000);
    push(32'h40000000, 32'h40000000);
    check_q("timeout", 32'h7FC00000, 1'b1);
    model_never = 1'b0;
    chk("timeout_rst_pulses", 32'(n_rst_pulses - snap), 32'd1);
    chk("timeout_wait_cycles", 32'(last_gap), 32'(TIMEOUT));
    check_q("after_timeout", 32'h40800000, 1'b0);

    // Output backpressure holds off the next issue
    idle(3);
    out_ready = 1'b0; model_lat = 3;
    push(32'h40A00000, 32'h40000000);
    push(32'h41000000, 32'h3F800000);
    wait_ov("bp");
    snap = n_issue;
    idle(20);
    chk("bp_no_issue",  32'(n_issue - snap), 32'd0);
    chk("bp_out_sum",   out_sum,             32'h40E00000);
    chk("bp_out_valid", {31'd0, out_valid},  32'd1);
    chk("bp_level",     {27'd0, level},      32'd1);
    out_ready = 1'b1;
    check_q("bp1", 32'h40E00000, 1'b0);
    check_q("bp2", 32'h41100000, 1'b0);

    // Reset while waiting on the adder with two pairs queued
    idle(3);
    model_never = 1'b1;
    push(32'h3F800000, 32'h40000000);
    push(32'h40000000, 32'h40000000);
    push(32'h3F800000, 32'h3F800000);
    idle(4);
    chk("mid_level_before", {27'd0, level}, 32'd2);
    reset = 1'b1;
    #1 chk("mid_add_reset_during", {31'd0, add_reset}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_level",     {27'd0, level},     32'd0);
    chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_add_reset", {31'd0, add_reset}, 32'd1);
    model_never = 1'b0;
    idle(TIMEOUT + 20);
    chk("mid_no_stale", 32'(res_q.size()), 32'd0);
    chk("mid_busy",     {31'd0, busy},     32'd0);

    // Simultaneous push and pop at level 2
    out_ready = 1'b0; model_lat = 3;
    push(32'h3F000000, 32'h3F000000);
    wait_ov("pp");
    push(32'h3F800000, 32'h3F800000);
    push(32'h40000000, 32'h40000000);
    chk("pp_level_pre", {27'd0, level}, 32'd2);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'h40A00000; in_b = 32'h40000000;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pp_level",  {27'd0, level}, 32'd2);
    chk("pp_popped", add_a,          32'h3F800000);
    check_q("pp1", 32'h3F800000, 1'b0);
    check_q("pp2", 32'h40000000, 1'b0);
    check_q("pp3", 32'h40800000, 1'b0);
    check_q("pp4", 32'h40E00000, 1'b0);

    idle(3);
    chk("start_reset_overlap", 32'(n_collide), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
